// File: rtl/keypad_pkg.sv
// Shared types and width helper for the matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        FR_NONE   = 2'd0,
        FR_SINGLE = 2'd1,
        FR_MULTI  = 2'd2
    } frame_kind_e;

    function automatic int code_w(input int rows, input int cols);
        int n;
        n = $clog2(rows * cols);
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Whole-frame stability filter: a frame result is accepted once it has
// been seen on DEBOUNCE consecutive frames.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 4,
    parameter int CODE_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_end,
    input  frame_kind_e       frame_kind,
    input  logic [CODE_W-1:0] frame_code,
    output logic              accept,
    output frame_kind_e       acc_kind,
    output logic [CODE_W-1:0] acc_code
);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    frame_kind_e       prev_kind_r;
    logic [CODE_W-1:0] prev_code_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              same_s;
    logic              hit_s;
    logic              accept_r;
    frame_kind_e       acc_kind_r;
    logic [CODE_W-1:0] acc_code_r;

    // Next stability count; a hit fires only on the frame that first reaches DEBOUNCE
    always_comb begin
        same_s = (frame_kind == prev_kind_r) && (frame_code == prev_code_r);
        if (!same_s) begin
            cnt_nxt_s = CNT_W'(1);
        end else if (cnt_r == CNT_W'(DEBOUNCE)) begin
            cnt_nxt_s = cnt_r;
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
        hit_s = (cnt_nxt_s == CNT_W'(DEBOUNCE)) && !(same_s && (cnt_r == CNT_W'(DEBOUNCE)));
    end

    // Track the previous frame and register the accepted result
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_kind_r <= FR_NONE;
            prev_code_r <= '0;
            cnt_r       <= '0;
            accept_r    <= 1'b0;
            acc_kind_r  <= FR_NONE;
            acc_code_r  <= '0;
        end else if (frame_end) begin
            prev_kind_r <= frame_kind;
            prev_code_r <= frame_code;
            cnt_r       <= cnt_nxt_s;
            accept_r    <= hit_s;
            acc_kind_r  <= frame_kind;
            acc_code_r  <= frame_code;
        end else begin
            accept_r    <= 1'b0;
        end
    end

    assign accept   = accept_r;
    assign acc_kind = acc_kind_r;
    assign acc_code = acc_code_r;

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: row drive, column synchroniser, per-frame key
// accumulation and the press/release event FSM.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 3,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4,
    localparam int CODE_W  = code_w(ROWS, COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COLS-1:0]   key_col,
    output logic [ROWS-1:0]   key_row,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_release,
    output logic              key_held,
    output logic              key_multi
);
    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int ROW_W  = $clog2(ROWS);
    localparam logic [0:0] S_IDLE    = ST_IDLE;
    localparam logic [0:0] S_PRESSED = ST_PRESSED;

    logic [COLS-1:0]   sync1_r;
    logic [COLS-1:0]   sync2_r;
    logic [SLOT_W-1:0] slot_r;
    logic [ROW_W-1:0]  row_r;
    logic [ROW_W-1:0]  row_nxt_s;
    logic              slot_wrap_s;
    logic              last_row_s;
    logic [ROWS-1:0]   key_row_r;
    logic [1:0]        frame_cnt_r;
    logic [1:0]        frame_cnt_s;
    logic [CODE_W-1:0] first_code_r;
    logic [CODE_W-1:0] hit_code_s;
    frame_kind_e       frame_kind_r;
    logic [CODE_W-1:0] frame_code_r;
    logic              frame_end_r;
    logic              accept_s;
    frame_kind_e       acc_kind_s;
    logic [CODE_W-1:0] acc_code_s;
    logic [0:0]        state_r;
    logic [CODE_W-1:0] code_r;
    logic              valid_r;
    logic              release_r;
    logic              held_r;
    logic              multi_r;

    // Row r is driven on bit ROWS-1-r
    function automatic logic [ROWS-1:0] row_drive(input logic [ROW_W-1:0] idx);
        logic [ROWS-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++) begin
            v[ROWS-1-r] = (idx == ROW_W'(r));
        end
        return v;
    endfunction

    // Slot wrap and next row index
    always_comb begin
        slot_wrap_s = (slot_r == SLOT_W'(SCAN_DIV - 1));
        last_row_s  = (row_r == ROW_W'(ROWS - 1));
        if (slot_wrap_s && last_row_s) begin
            row_nxt_s = '0;
        end else if (slot_wrap_s) begin
            row_nxt_s = row_r + ROW_W'(1);
        end else begin
            row_nxt_s = row_r;
        end
    end

    // Scan counters, row drive and column synchroniser
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_r    <= '0;
            row_r     <= '0;
            key_row_r <= {1'b1, {(ROWS-1){1'b0}}};
            sync1_r   <= '0;
            sync2_r   <= '0;
        end else begin
            slot_r    <= slot_wrap_s ? '0 : slot_r + SLOT_W'(1);
            row_r     <= row_nxt_s;
            key_row_r <= row_drive(row_nxt_s);
            sync1_r   <= key_col;
            sync2_r   <= sync1_r;
        end
    end

    // Merge this row's columns into the running frame count and first code
    always_comb begin
        int hits;
        int first_col;
        int total;
        int code_int;
        hits      = 0;
        first_col = 0;
        for (int c = COLS - 1; c >= 0; c--) begin
            hits      = hits + int'(sync2_r[COLS-1-c]);
            first_col = sync2_r[COLS-1-c] ? c : first_col;
        end
        total       = int'(frame_cnt_r) + hits;
        frame_cnt_s = (total >= 2) ? 2'd2 : 2'(total);
        code_int    = int'(row_r) * COLS + first_col;
        hit_code_s  = ((frame_cnt_r == 2'd0) && (hits != 0)) ? CODE_W'(code_int) : first_code_r;
    end

    // Frame accumulation; result and frame_end strobe follow the last-row sample
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_r  <= 2'd0;
            first_code_r <= '0;
            frame_kind_r <= FR_NONE;
            frame_code_r <= '0;
            frame_end_r  <= 1'b0;
        end else if (slot_wrap_s && last_row_s) begin
            frame_cnt_r  <= 2'd0;
            first_code_r <= '0;
            frame_end_r  <= 1'b1;
            case (frame_cnt_s)
                2'd0: begin
                    frame_kind_r <= FR_NONE;
                    frame_code_r <= '0;
                end
                2'd1: begin
                    frame_kind_r <= FR_SINGLE;
                    frame_code_r <= hit_code_s;
                end
                default: begin
                    frame_kind_r <= FR_MULTI;
                    frame_code_r <= '0;
                end
            endcase
        end else if (slot_wrap_s) begin
            frame_cnt_r  <= frame_cnt_s;
            first_code_r <= hit_code_s;
            frame_end_r  <= 1'b0;
        end else begin
            frame_end_r  <= 1'b0;
        end
    end

    keypad_debounce #(
        .DEBOUNCE (DEBOUNCE),
        .CODE_W   (CODE_W)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .frame_end  (frame_end_r),
        .frame_kind (frame_kind_r),
        .frame_code (frame_code_r),
        .accept     (accept_s),
        .acc_kind   (acc_kind_s),
        .acc_code   (acc_code_s)
    );

    // Event FSM: a new press is only reported after the held key is released
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            code_r    <= '0;
            valid_r   <= 1'b0;
            release_r <= 1'b0;
            held_r    <= 1'b0;
            multi_r   <= 1'b0;
        end else if (accept_s) begin
            valid_r   <= 1'b0;
            release_r <= 1'b0;
            case (acc_kind_s)
                FR_SINGLE: begin
                    multi_r <= 1'b0;
                    if (state_r == S_IDLE) begin
                        code_r  <= acc_code_s;
                        valid_r <= 1'b1;
                        held_r  <= 1'b1;
                        state_r <= S_PRESSED;
                    end else begin
                        state_r <= state_r;
                    end
                end
                FR_MULTI: begin
                    multi_r <= 1'b1;
                end
                default: begin
                    multi_r <= 1'b0;
                    if (state_r == S_PRESSED) begin
                        release_r <= 1'b1;
                        held_r    <= 1'b0;
                        state_r   <= S_IDLE;
                    end else begin
                        state_r   <= state_r;
                    end
                end
            endcase
        end else begin
            valid_r   <= 1'b0;
            release_r <= 1'b0;
        end
    end

    assign key_row     = key_row_r;
    assign key_code    = code_r;
    assign key_valid   = valid_r;
    assign key_release = release_r;
    assign key_held    = held_r;
    assign key_multi   = multi_r;

endmodule
